// File: rtl/compositor_pkg.sv
// Shared types for the layer compositor: fade FSM states, tint modes and pixel struct.
package compositor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    SAT,
    DECAY
  } fade_state_t;

  typedef enum logic [1:0] {
    TINT_NONE,
    TINT_WIN,
    TINT_LOSE
  } tint_t;

  localparam int unsigned ColorW = 8;

  typedef struct packed {
    logic [ColorW-1:0] r;
    logic [ColorW-1:0] g;
    logic [ColorW-1:0] b;
  } rgb_t;

  // Mode 2'b11 is reserved and behaves as no tint.
  function automatic tint_t decode_tint(input logic [1:0] mode);
    tint_t t;
    case (mode)
      2'b01:   t = TINT_WIN;
      2'b10:   t = TINT_LOSE;
      default: t = TINT_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fade_fsm.sv
// Frame-rate fade controller: divider, state and saturating fade level, advanced only on
// frame_tick so the level never changes mid-frame.
module fade_fsm
  import compositor_pkg::*;
#(
  parameter int unsigned FADE_W   = 3,
  parameter int unsigned FADE_DIV = 16
) (
  input  logic              pixel_clk,
  input  logic              Reset_n,
  input  logic              frame_tick,
  input  logic              fade_req,
  output logic [FADE_W-1:0] fade_level,
  output logic              fade_max
);

  localparam int unsigned DivW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(FADE_DIV - 1);
  localparam logic [FADE_W-1:0] LevelMax = '1;
  localparam logic [FADE_W-1:0] LevelOne = FADE_W'(1);

  fade_state_t       state_q;
  logic [DivW-1:0]   div_q;
  logic [FADE_W-1:0] level_q;
  logic              max_q;
  logic              step;

  assign step = (div_q == DivLast);

  // Direction changes are tested before the step so they win on a shared tick.
  always_ff @(posedge pixel_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      level_q <= '0;
      max_q   <= 1'b0;
    end else if (frame_tick) begin
      unique case (state_q)
        IDLE: begin
          div_q <= '0;
          if (fade_req) state_q <= RAMP;
        end
        RAMP: begin
          if (!fade_req) begin
            state_q <= DECAY;
            div_q   <= '0;
          end else if (step) begin
            div_q <= '0;
            if (level_q >= LevelMax - LevelOne) begin
              level_q <= LevelMax;
              state_q <= SAT;
              max_q   <= 1'b1;
            end else begin
              level_q <= level_q + LevelOne;
            end
          end else begin
            div_q <= div_q + DivW'(1);
          end
        end
        SAT: begin
          div_q <= '0;
          if (!fade_req) begin
            state_q <= DECAY;
            max_q   <= 1'b0;
          end
        end
        DECAY: begin
          if (fade_req) begin
            state_q <= RAMP;
            div_q   <= '0;
          end else if (step) begin
            div_q <= '0;
            if (level_q <= LevelOne) begin
              level_q <= '0;
              state_q <= IDLE;
            end else begin
              level_q <= level_q - LevelOne;
            end
          end else begin
            div_q <= div_q + DivW'(1);
          end
        end
      endcase
    end
  end

  assign fade_level = level_q;
  assign fade_max   = max_q;

endmodule

// File: rtl/layer_compositor.sv
// Priority layer compositor: picks the highest-priority opaque layer, then fades, tints and
// blanks it through a two-stage pixel pipeline.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned COLOR_W    = 8,
  parameter int unsigned FADE_W     = 3,
  parameter int unsigned FADE_DIV   = 16
) (
  input  logic                              pixel_clk,
  input  logic                              Reset_n,
  input  logic                              frame_tick,
  input  logic                              blank,
  input  logic [NUM_LAYERS-1:0]             layer_valid,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0]   layer_rgb,
  input  logic [NUM_LAYERS-1:0]             layer_fade_en,
  input  logic [3*COLOR_W-1:0]              bg_rgb,
  input  logic                              fade_req,
  input  logic [1:0]                        tint_mode,
  output logic [COLOR_W-1:0]                Red,
  output logic [COLOR_W-1:0]                Green,
  output logic [COLOR_W-1:0]                Blue,
  output logic [FADE_W-1:0]                 fade_level,
  output logic                              fade_max
);

  localparam int unsigned PixW = 3 * COLOR_W;

  fade_fsm #(
    .FADE_W  (FADE_W),
    .FADE_DIV(FADE_DIV)
  ) u_fade_fsm (
    .pixel_clk (pixel_clk),
    .Reset_n   (Reset_n),
    .frame_tick(frame_tick),
    .fade_req  (fade_req),
    .fade_level(fade_level),
    .fade_max  (fade_max)
  );

  logic [PixW-1:0] sel_rgb;
  logic            sel_fade;
  logic            sel_bg;

  // Walk from lowest to highest priority so the lowest valid index wins.
  always_comb begin
    sel_rgb  = bg_rgb;
    sel_fade = 1'b1;
    sel_bg   = 1'b1;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_valid[i]) begin
        sel_rgb  = layer_rgb[i*PixW +: PixW];
        sel_fade = layer_fade_en[i];
        sel_bg   = 1'b0;
      end
    end
  end

  logic [PixW-1:0] s1_rgb_q;
  logic            s1_fade_q;
  logic            s1_bg_q;
  logic            s1_blank_q;
  tint_t           s1_tint_q;

  always_ff @(posedge pixel_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_rgb_q   <= '0;
      s1_fade_q  <= 1'b0;
      s1_bg_q    <= 1'b0;
      s1_blank_q <= 1'b0;
      s1_tint_q  <= TINT_NONE;
    end else begin
      s1_rgb_q   <= sel_rgb;
      s1_fade_q  <= sel_fade;
      s1_bg_q    <= sel_bg;
      s1_blank_q <= blank;
      s1_tint_q  <= decode_tint(tint_mode);
    end
  end

  logic [FADE_W-1:0]  shamt;
  logic [COLOR_W-1:0] r_f, g_f, b_f;
  logic [COLOR_W-1:0] red_d, green_d, blue_d;

  assign shamt = s1_fade_q ? fade_level : '0;
  assign r_f   = s1_rgb_q[PixW-1 -: COLOR_W] >> shamt;
  assign g_f   = s1_rgb_q[2*COLOR_W-1 -: COLOR_W] >> shamt;
  assign b_f   = s1_rgb_q[COLOR_W-1:0] >> shamt;

  always_comb begin
    red_d   = r_f;
    green_d = g_f;
    blue_d  = b_f;
    unique case (s1_tint_q)
      TINT_WIN: begin
        if (s1_bg_q) red_d = '1;
      end
      TINT_LOSE: begin
        red_d  = g_f;
        blue_d = g_f;
      end
      default: ;
    endcase
    if (!s1_blank_q) begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
    end
  end

  logic [COLOR_W-1:0] red_q, green_q, blue_q;

  always_ff @(posedge pixel_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign Red   = red_q;
  assign Green = green_q;
  assign Blue  = blue_q;

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised pixel compositor that replaces the fixed player/AI/obstacle/background mux in the video path. Selects the highest-priority opaque layer per pixel, applies a per-layer fade (right shift) driven by a frame-rate fade state machine, applies a global game-state tint, and registers the result through a two-stage pipeline. Sits between the per-object plot blocks and the VGA DAC outputs, clocked by the pixel clock.

## Interface
- NUM_LAYERS, 4, number of sprite layers; index 0 is highest priority.
- COLOR_W, 8, bits per colour channel.
- FADE_W, 3, width of fade level; maximum level is 2**FADE_W-1.
- FADE_DIV, 16, frame ticks per fade step; must be at least 1.

- pixel_clk  in  1  pixel clock; sole clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per frame, asserted only during vertical blanking.
- blank  in  1  active-high display-enable; low means blanking, so output black.
- layer_valid  in  NUM_LAYERS  per-layer opaque flag for the current pixel.
- layer_rgb  in  NUM_LAYERS x 3*COLOR_W  per-layer {R,G,B}.
- layer_fade_en  in  NUM_LAYERS  layer is subject to fade shift.
- bg_rgb  in  3*COLOR_W  background {R,G,B}; always faded.
- fade_req  in  1  fade condition, e.g. collision; sampled on frame_tick only.
- tint_mode  in  2  00 none, 01 win (red), 10 lose (mono), 11 treated as 00.
- Red, Green, Blue  out  COLOR_W each  registered pixel colour.
- fade_level  out  FADE_W  current fade shift.
- fade_max  out  1  high while the fade FSM is in SAT.

## Operation
- Select: pick the lowest index i with layer_valid[i]. Fade applies if layer_fade_en[i]. If no layer is valid, use bg_rgb, which is always faded and marked as background.
- Fade: each channel is logically right-shifted by fade_level. Fade level 0 means pass-through.
- Tint is applied after fade:
  - 01: Red forced to all-ones on background pixels only; other channels and sprite pixels unchanged.
  - 10: all three channels take the faded Green value, on every pixel.
- Blanking: if the pipeline-delayed blank is low, outputs are 0 regardless of layers or tint.
- Fade FSM advances only on frame_tick. A divider counts 0..FADE_DIV-1 and a step fires when it wraps.
  - IDLE: level 0, divider held at 0. Go to RAMP on a tick with fade_req=1.
  - RAMP: on each step, level+1. On reaching the maximum, go to SAT. If fade_req=0 at a tick, go to DECAY and clear the divider.
  - SAT: level held at maximum and fade_max=1. If fade_req=0 at a tick, go to DECAY and clear the divider.
  - DECAY: on each step, level-1. On reaching 0, go to IDLE. If fade_req=1 at a tick, go to RAMP and clear the divider.
- Simultaneous events: a direction change wins over a pending step on the same tick, so the level does not change on that tick.
- Level changes only on frame_tick, which falls in vblank, so no mid-frame tearing.

## Timing
- Latency is 2 pixel_clk from inputs (layer_*, bg_rgb, blank, tint_mode) to Red/Green/Blue.
  - Stage 1 registers the selected colour, fade flag, background flag and blank.
  - Stage 2 registers shift, tint and blank gating.
- fade_level is sampled into stage 2 in the same cycle the shift is computed, with no extra delay.
- Reset values (asynchronous, on Reset_n low):
  - Red, Green, Blue = 0; fade_level = 0; fade_max = 0.
  - FSM in IDLE, divider 0, pipeline valid/blank registers 0.
- Reset asserted mid-frame: outputs go to 0 immediately. The first valid pixel appears 2 clocks after release.
- Width rules: divider is clog2(FADE_DIV) bits, minimum 1. Level arithmetic saturates and never wraps.

## Structure
- Package `compositor_pkg` holds:
  - `fade_state_t` enum: IDLE, RAMP, SAT, DECAY.
  - `tint_t` enum: TINT_NONE, TINT_WIN, TINT_LOSE.
  - `rgb_t` packed struct {r,g,b} sized by COLOR_W.
- One sub-module, `fade_fsm`, contains the divider, state register and level. It has ports pixel_clk, Reset_n, frame_tick, fade_req, fade_level, fade_max.
- Priority select and pipeline stay in the top module.

## Test plan
- Priority: layer_valid=4'b0110, layer 1 = 0x112233, layer 2 = 0xAABBCC, level 0 -> 0x112233 two clocks later. Layer_valid=0 with bg 0x404040 -> 0x404040.
- Fade ramp: FADE_DIV=2, fade_req=1 held for 16 ticks -> level goes 0,1,…,7 with one step per 2 ticks. fade_max rises when level reaches 7. Background 0x808080 then outputs 0x010101.
- Decay and reversal: in SAT, drop fade_req -> level decrements 7→6 after 2 ticks. Raise fade_req on the tick a step would fire -> level holds at 6 and then ramps again.
- Fade enable: level 3, layer 0 valid with fade_en=0 and colour 0xF0F0F0 -> 0xF0F0F0. With fade_en=1 -> 0x1E1E1E.
- Tint: tint_mode=01, bg 0x204060, level 1 -> 0xFF2030. Sprite pixel unchanged. tint_mode=10 on 0x204060, level 0 -> 0x404040.
- Blank/reset: blank=0 -> 0x000000 two clocks later. Pulse Reset_n low mid-ramp -> outputs 0, fade_level 0, FSM in IDLE asynchronously.
